// File: rtl/fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// fifo_sync_flags
//
// Single-clock FIFO with storage, occupancy tracking and status flags.
// The FIFO depth can be any integer of 2 or more. The read and write
// pointers wrap at depth-1.
//
// The status flags (full, pndng, almost_full, almost_empty) are decoded from
// the occupancy count, not from pointer comparison. They are held in
// registers and load the decode of the next count. As a result, no output
// has a combinational path from push, pop or data_in.
//
// data_out is the show-ahead head entry. It is read combinationally from the
// registered read pointer and the memory.
//
// Parameters
//   bits    data word width (>= 1)
//   depth   number of entries (>= 2)
//   af_lvl  almost_full when count >= af_lvl   (1 .. depth)
//   ae_lvl  almost_empty when count <= ae_lvl  (0 .. depth-1)
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-low reset
//   push         in   write request, data_in captured on the same edge
//   pop          in   read request, advances the head
//   clr_err      in   clears the sticky overflow/underflow flags
//   data_in      in   write data
//   data_out     out  head entry, valid while pndng = 1
//   full         out  count == depth
//   pndng        out  count != 0
//   almost_full  out  count >= af_lvl
//   almost_empty out  count <= ae_lvl
//   count        out  current occupancy
//   pointer_in   out  next write slot
//   pointer_out  out  current read slot
//   overflow     out  sticky: a push was rejected
//   underflow    out  sticky: a pop was rejected
// -----------------------------------------------------------------------------
module fifo_sync_flags #(
    parameter int bits   = 4,
    parameter int depth  = 4,
    parameter int af_lvl = depth - 1,
    parameter int ae_lvl = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    input  logic [bits-1:0]            data_in,
    output logic [bits-1:0]            data_out,
    output logic                       full,
    output logic                       pndng,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(depth+1)-1:0] count,
    output logic [$clog2(depth)-1:0]   pointer_in,
    output logic [$clog2(depth)-1:0]   pointer_out,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(depth + 1);
    localparam int PW = $clog2(depth);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(depth);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);

    // ---------------------------------------------------------------------
    // Helper functions
    // ---------------------------------------------------------------------

    // The pointer wraps at the last real slot. This matters when depth is not
    // a power of two.
    function automatic logic [PW-1:0] ptr_advance(input logic [PW-1:0] p);
        ptr_advance = (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
    endfunction

    function automatic logic dec_full(input logic [CW-1:0] c);
        dec_full = (c == CNT_MAX);
    endfunction

    function automatic logic dec_pndng(input logic [CW-1:0] c);
        dec_pndng = (c != CNT_ZERO);
    endfunction

    function automatic logic dec_almost_full(input logic [CW-1:0] c);
        dec_almost_full = (int'(c) >= af_lvl);
    endfunction

    function automatic logic dec_almost_empty(input logic [CW-1:0] c);
        dec_almost_empty = (int'(c) <= ae_lvl);
    endfunction

    // Sticky flag update. A new event wins over a clear in the same cycle.
    function automatic logic sticky_next(input logic cur, input logic evt,
                                         input logic clr);
        sticky_next = evt ? 1'b1 : (clr ? 1'b0 : cur);
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [bits-1:0] r_mem [depth];
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_ptr_in;
    logic [PW-1:0]   r_ptr_out;
    logic            r_full;
    logic            r_pndng;
    logic            r_almost_full;
    logic            r_almost_empty;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_push_acc;
    logic            w_pop_acc;
    logic            w_ovf_evt;
    logic            w_unf_evt;
    logic [CW-1:0]   w_count_nxt;
    logic [PW-1:0]   w_ptr_in_nxt;
    logic [PW-1:0]   w_ptr_out_nxt;

    // Accept/reject decisions. These are taken from the registered flags only.
    always_comb begin
        // When the FIFO is full, a push is accepted only if a pop frees a slot
        // on the same edge. Because depth >= 2, full also implies pndng, so
        // that pop is always accepted.
        w_push_acc = push & (~r_full | pop);
        w_pop_acc  = pop & r_pndng;
        w_ovf_evt  = push & r_full & ~pop;
        w_unf_evt  = pop & ~r_pndng;
    end

    // Next occupancy. When a push and a pop are both accepted, the count holds.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            2'b11:   w_count_nxt = r_count;
            default: w_count_nxt = r_count;
        endcase
    end

    // Next pointer values.
    always_comb begin
        w_ptr_in_nxt  = w_push_acc ? ptr_advance(r_ptr_in)  : r_ptr_in;
        w_ptr_out_nxt = w_pop_acc  ? ptr_advance(r_ptr_out) : r_ptr_out;
    end

    // Storage write. The memory is not cleared by reset, but a write in the
    // reset cycle is suppressed because reset has priority over push.
    always_ff @(posedge clk) begin
        if (rst && w_push_acc) begin
            r_mem[r_ptr_in] <= data_in;
        end
    end

    // Pointers and count, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count   <= CNT_ZERO;
            r_ptr_in  <= PTR_ZERO;
            r_ptr_out <= PTR_ZERO;
        end else begin
            r_count   <= w_count_nxt;
            r_ptr_in  <= w_ptr_in_nxt;
            r_ptr_out <= w_ptr_out_nxt;
        end
    end

    // Status flags. Each one is the registered decode of the next count, so
    // it always matches the count register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full         <= dec_full(CNT_ZERO);
            r_pndng        <= dec_pndng(CNT_ZERO);
            r_almost_full  <= dec_almost_full(CNT_ZERO);
            r_almost_empty <= dec_almost_empty(CNT_ZERO);
        end else begin
            r_full         <= dec_full(w_count_nxt);
            r_pndng        <= dec_pndng(w_count_nxt);
            r_almost_full  <= dec_almost_full(w_count_nxt);
            r_almost_empty <= dec_almost_empty(w_count_nxt);
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= sticky_next(r_overflow,  w_ovf_evt, clr_err);
            r_underflow <= sticky_next(r_underflow, w_unf_evt, clr_err);
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign data_out     = r_mem[r_ptr_out];
    assign full         = r_full;
    assign pndng        = r_pndng;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign pointer_in   = r_ptr_in;
    assign pointer_out  = r_ptr_out;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_flags
//
// Directed testbench for fifo_sync_flags with depth=4, bits=4, af_lvl=3,
// ae_lvl=1. Inputs are driven 1 time unit after a rising edge. Outputs are
// checked 1 time unit after the next rising edge. Every expected value is
// written out by hand.
// -----------------------------------------------------------------------------
module tb_fifo_sync_flags;

    logic       clk;
    logic       rst;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       full;
    logic       pndng;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic [1:0] pointer_in;
    logic [1:0] pointer_out;
    logic       overflow;
    logic       underflow;

    int n_checks;
    int n_errors;

    fifo_sync_flags #(
        .bits  (4),
        .depth (4),
        .af_lvl(3),
        .ae_lvl(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .pndng       (pndng),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .pointer_in  (pointer_in),
        .pointer_out (pointer_out),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count the check.
    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q, input logic c,
                       input logic [3:0] d);
        push    = p;
        pop     = q;
        clr_err = c;
        data_in = d;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        data_in = 4'h0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        clr_err  = 1'b0;
        data_in  = 4'h0;

        // Reset
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        rst = 1'b1;
        check("rst_count", count, 0);
        check("rst_pin", pointer_in, 0);
        check("rst_pout", pointer_out, 0);
        check("rst_full", full, 0);
        check("rst_pndng", pndng, 0);
        check("rst_af", almost_full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        // Fill with 1, 2, 3, 4
        cyc(1'b1, 1'b0, 1'b0, 4'h1);
        check("f1_count", count, 1);
        check("f1_pndng", pndng, 1);
        check("f1_ae", almost_empty, 1);
        check("f1_dout", data_out, 1);
        check("f1_pin", pointer_in, 1);
        cyc(1'b1, 1'b0, 1'b0, 4'h2);
        check("f2_count", count, 2);
        check("f2_ae", almost_empty, 0);
        check("f2_af", almost_full, 0);
        cyc(1'b1, 1'b0, 1'b0, 4'h3);
        check("f3_count", count, 3);
        check("f3_af", almost_full, 1);
        check("f3_full", full, 0);
        cyc(1'b1, 1'b0, 1'b0, 4'h4);
        check("f4_count", count, 4);
        check("f4_full", full, 1);
        check("f4_pin_wrap", pointer_in, 0);
        check("f4_dout", data_out, 1);

        // Overflow: push alone while full
        cyc(1'b1, 1'b0, 1'b0, 4'hF);
        check("ov_count", count, 4);
        check("ov_flag", overflow, 1);
        check("ov_pin", pointer_in, 0);
        check("ov_unf", underflow, 0);

        // Drain: the heads must be 2, 3, 4 and never F
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("d1_dout", data_out, 2);
        check("d1_count", count, 3);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("d2_dout", data_out, 3);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("d3_dout", data_out, 4);
        check("d3_count", count, 1);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("d4_count", count, 0);
        check("d4_pndng", pndng, 0);
        check("d4_pout", pointer_out, 0);
        check("d4_unf", underflow, 0);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("d5_unf", underflow, 1);
        check("d5_count", count, 0);
        check("d5_ovf_sticky", overflow, 1);

        // Clear both error flags
        cyc(1'b0, 1'b0, 1'b1, 4'h0);
        check("clr_ovf", overflow, 0);
        check("clr_unf", underflow, 0);

        // Simultaneous push and pop while full
        cyc(1'b1, 1'b0, 1'b0, 4'h5);
        cyc(1'b1, 1'b0, 1'b0, 4'h6);
        cyc(1'b1, 1'b0, 1'b0, 4'h7);
        cyc(1'b1, 1'b0, 1'b0, 4'h8);
        check("sf_pre_full", full, 1);
        cyc(1'b1, 1'b1, 1'b0, 4'hA);
        check("sf_count", count, 4);
        check("sf_full", full, 1);
        check("sf_pin", pointer_in, 1);
        check("sf_pout", pointer_out, 1);
        check("sf_ovf", overflow, 0);
        check("sf_unf", underflow, 0);
        check("sf_dout", data_out, 6);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("sf_d1", data_out, 7);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("sf_d2", data_out, 8);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("sf_last", data_out, 10);
        check("sf_last_count", count, 1);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("sf_empty", pndng, 0);

        // Simultaneous push and pop while empty
        cyc(1'b1, 1'b1, 1'b0, 4'h7);
        check("se_count", count, 1);
        check("se_unf", underflow, 1);
        check("se_pndng", pndng, 1);
        check("se_dout", data_out, 7);

        // Error clear, then a clear that coincides with a new underflow
        cyc(1'b0, 1'b0, 1'b1, 4'h0);
        check("ec_unf", underflow, 0);
        check("ec_ovf", overflow, 0);
        cyc(1'b0, 1'b1, 1'b0, 4'h0);
        check("ec_empty", count, 0);
        check("ec_unf_quiet", underflow, 0);
        cyc(1'b0, 1'b1, 1'b1, 4'h0);
        check("ec_set_wins", underflow, 1);

        // Reset in the middle of a stream
        cyc(1'b1, 1'b0, 1'b0, 4'h1);
        cyc(1'b1, 1'b0, 1'b0, 4'h2);
        check("mr_pre_count", count, 2);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 4'h3);
        rst = 1'b1;
        check("mr_count", count, 0);
        check("mr_pin", pointer_in, 0);
        check("mr_pout", pointer_out, 0);
        check("mr_pndng", pndng, 0);
        check("mr_ae", almost_empty, 1);
        check("mr_af", almost_full, 0);
        check("mr_unf", underflow, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
